// File: rtl/blk_efff95_pkg.sv
// Shared constants and helpers for the peripheral-subsystem interrupt aggregator.
// Register addresses, VECTOR layout and the lowest-index priority encoder.
package blk_efff95_pkg;

  localparam int MAX_IRQ          = 16;
  localparam int VECTOR_VALID_BIT = 15;
  localparam int VECTOR_ID_W      = 4;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_ENABLE  = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_SET     = 3'd5;

  // Scans high to low so the last hit, the lowest set index, wins.
  function automatic logic [VECTOR_ID_W-1:0] lowest_index(input logic [MAX_IRQ-1:0] v);
    lowest_index = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = VECTOR_ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/irq_ctrl_sync_edge.sv
// Two-flop synchroniser per interrupt source plus a third flop for rise detection.
// level is the synchronised input; rise pulses for one cycle on a 0->1 transition.
module irq_ctrl_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] s1, s2, s3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/blk_efff95.sv
// Interrupt aggregator: latches edge/level sources, applies enables, and exposes
// a combined irq plus a lowest-index vector over a 16-bit register slave.
module blk_efff95
  import blk_efff95_pkg::*;
#(
  parameter int          NUM_IRQ   = 8,
  parameter logic [15:0] EDGE_MASK = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [15:0]        readdata,
  output logic               irq
);

  localparam logic [15:0] VALID_MASK = (NUM_IRQ >= MAX_IRQ) ? 16'hFFFF
                                     : 16'((32'd1 << NUM_IRQ) - 32'd1);
  localparam logic [15:0] EDGE_BITS  = EDGE_MASK & VALID_MASK;
  localparam logic [15:0] LEVEL_BITS = ~EDGE_MASK & VALID_MASK;

  logic [NUM_IRQ-1:0] sync_level, sync_rise;
  logic [15:0] level16, rise16, wdata, clr_bits, set_bits;
  logic [15:0] pending, pending_nxt, enable, active, vector, rd_mux;
  logic        wr_en;

  irq_ctrl_sync_edge #(.WIDTH(NUM_IRQ)) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (irq_in),
    .level    (sync_level),
    .rise     (sync_rise)
  );

  // Everything is carried 16 bits wide; bits at or above NUM_IRQ stay zero.
  always_comb begin
    level16                = '0;
    rise16                 = '0;
    level16[NUM_IRQ-1:0]   = sync_level;
    rise16[NUM_IRQ-1:0]    = sync_rise;
    wr_en    = chipselect & ~write_n;
    wdata    = writedata & VALID_MASK;
    clr_bits = (wr_en && address == ADDR_PENDING) ? wdata : '0;
    set_bits = (wr_en && address == ADDR_SET)     ? wdata : '0;
    // An edge arriving with a W1C of the same bit keeps the bit set.
    pending_nxt = (level16 & LEVEL_BITS)
                | (EDGE_BITS & ((pending & ~clr_bits) | rise16 | set_bits));
    active = pending & enable;
    vector = '0;
    vector[VECTOR_VALID_BIT]  = |active;
    vector[VECTOR_ID_W-1:0]   = lowest_index(active);
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATUS:  rd_mux = level16;
      ADDR_PENDING: rd_mux = pending;
      ADDR_ENABLE:  rd_mux = enable;
      ADDR_ACTIVE:  rd_mux = active;
      ADDR_VECTOR:  rd_mux = vector;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      enable   <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      if (wr_en && address == ADDR_ENABLE) enable <= wdata;
      readdata <= rd_mux;
      irq      <= |active;
    end
  end

endmodule

// File: tb/tb_blk_efff95.sv
// Scoreboard bench for blk_efff95: a delay-line reference model predicts reads and irq,
// a negedge monitor pops and compares. Directed scenarios followed by random traffic.
module tb_blk_efff95;

  localparam int          NUM_IRQ   = 8;
  localparam logic [15:0] EDGE_MASK = 16'h0035;
  localparam logic [15:0] VALID     = 16'h00FF;

  logic               clk;
  logic               reset_n;
  logic [2:0]         address;
  logic               chipselect;
  logic               write_n;
  logic [15:0]        writedata;
  logic [NUM_IRQ-1:0] irq_in;
  logic [15:0]        readdata;
  logic               irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] hist[$];
  logic [15:0] m_pend, m_en;
  logic        m_irq, rd_vld;
  logic [15:0] t_lvl, t_prv, t_rise, t_wd, t_clr, t_set;
  logic        t_wr;

  blk_efff95 #(.NUM_IRQ(NUM_IRQ), .EDGE_MASK(EDGE_MASK)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .irq_in     (irq_in),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_vector(input logic [15:0] act);
    ref_vector = 16'h0000;
    for (int i = 15; i >= 0; i--) begin
      if (act[i]) ref_vector = 16'h8000 | 16'(i);
    end
  endfunction

  function automatic logic [15:0] ref_read(input logic [2:0] a, input logic [15:0] lvl,
                                           input logic [15:0] pend, input logic [15:0] en);
    case (a)
      3'd0:    ref_read = lvl;
      3'd1:    ref_read = pend;
      3'd2:    ref_read = en;
      3'd3:    ref_read = pend & en;
      3'd4:    ref_read = ref_vector(pend & en);
      default: ref_read = 16'h0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the synchronised level seen at a clock edge is the input sampled two
  // edges earlier; a rise is that sample high while the one before it was low.
  initial begin
    m_pend = '0; m_en = '0; m_irq = 1'b0; rd_vld = 1'b0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        hist.delete();
        exp_q.delete();
        m_pend = '0; m_en = '0; m_irq = 1'b0; rd_vld = 1'b0;
      end else begin
        t_lvl  = (hist.size() >= 2) ? hist[hist.size()-2] : 16'h0000;
        t_prv  = (hist.size() >= 3) ? hist[hist.size()-3] : 16'h0000;
        t_rise = t_lvl & ~t_prv;
        t_wd   = writedata & VALID;
        t_wr   = chipselect && !write_n;
        t_clr  = (t_wr && address == 3'd1) ? t_wd : 16'h0000;
        t_set  = (t_wr && address == 3'd5) ? t_wd : 16'h0000;
        rd_vld = chipselect && write_n;
        if (rd_vld) exp_q.push_back(ref_read(address, t_lvl, m_pend, m_en));
        m_irq  = |(m_pend & m_en);
        m_pend = (t_lvl & ~EDGE_MASK & VALID)
               | (EDGE_MASK & VALID & ((m_pend & ~t_clr) | t_rise | t_set));
        if (t_wr && address == 3'd2) m_en = t_wd;
        hist.push_back({8'h00, irq_in});
        if (hist.size() > 3) void'(hist.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("irq", {15'b0, irq}, {15'b0, m_irq});
      if (rd_vld) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL readdata: got 0x%04h but no read expected", readdata);
        end else begin
          check("readdata", readdata, exp_q.pop_front());
        end
      end
    end
  end

  task automatic bus(input logic cs, input logic wn, input logic [2:0] a, input logic [15:0] d);
    chipselect = cs; write_n = wn; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    bus(1'b1, 1'b1, a, 16'h0000);
  endtask

  task automatic idle(input int n);
    repeat (n) bus(1'b0, 1'b1, 3'd0, 16'h0000);
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = '0; writedata = '0; irq_in = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int a = 0; a < 8; a++) rd(3'(a));

    // single-cycle pulse on edge source 0, then W1C
    wr(3'd2, 16'h0001);
    irq_in[0] = 1'b1;
    idle(1);
    irq_in[0] = 1'b0;
    idle(5);
    rd(3'd1);
    wr(3'd1, 16'h0001);
    idle(2);
    rd(3'd1);

    // level source 3: W1C has no effect, deassert drops irq
    irq_in[3] = 1'b1;
    wr(3'd2, 16'h0008);
    idle(4);
    rd(3'd4);
    wr(3'd1, 16'h0008);
    rd(3'd1);
    irq_in[3] = 1'b0;
    idle(4);

    // two edge sources: vector walks up as each is cleared
    wr(3'd2, 16'h0024);
    irq_in[2] = 1'b1; irq_in[5] = 1'b1;
    idle(1);
    irq_in[2] = 1'b0; irq_in[5] = 1'b0;
    idle(4);
    rd(3'd4);
    wr(3'd1, 16'h0004);
    rd(3'd4);
    wr(3'd1, 16'h0020);
    rd(3'd4);

    // rise on source 0 in the same cycle as a W1C of bit 0
    wr(3'd2, 16'h0000);
    wr(3'd5, 16'h0001);
    irq_in[0] = 1'b1;
    idle(2);
    wr(3'd1, 16'h0001);
    irq_in[0] = 1'b0;
    rd(3'd1);
    wr(3'd1, 16'h0001);
    rd(3'd1);

    // SET while disabled, then enable, then asynchronous reset mid-run
    wr(3'd5, 16'h0010);
    idle(2);
    wr(3'd2, 16'h0010);
    idle(2);
    irq_in[3] = 1'b1;
    rd(3'd1);
    check("pre_reset_irq", {15'b0, irq}, 16'h0001);
    #2 reset_n = 1'b0;
    #1;
    check("reset_irq", {15'b0, irq}, 16'h0000);
    check("reset_readdata", readdata, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(4);
    rd(3'd1);
    rd(3'd0);
    irq_in = '0;
    idle(3);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ 8'($urandom);
      case ($urandom_range(0, 3))
        0: idle(1);
        1: wr(3'($urandom_range(0, 7)), 16'($urandom));
        2: wr(3'($urandom_range(1, 2)), 16'($urandom));
        default: rd(3'($urandom_range(0, 7)));
      endcase
    end

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
